// File: rtl/bram_fifo_ctrl.sv
// Purpose: first-word-fall-through FIFO controller wrapped around a 1-cycle-read dual-port block RAM.
// Latency: push in cycle T is visible at the head (out_valid) in cycle T+3; 1 flit/cycle sustained.
// Backpressure: in_ready drops when the RAM holds DEPTH entries; out_ready stalls the 2-entry output stage.
//
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   flush                synchronous clear of all contents, wins over push/pop
//   in_valid/in_data/in_ready     upstream valid/ready link
//   out_valid/out_data/out_ready  head flit to downstream, valid/ready
//   level                flits held: RAM + in-flight read + output stage
//   ram_wen/ram_waddr/ram_din     RAM write port (RAM enable tied high outside)
//   ram_raddr/ram_dout            RAM read port; ram_dout valid the cycle after ram_raddr
module bram_fifo_ctrl #(
    parameter int WIDTH   = 36,
    parameter int LOG_DEP = 6
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic [LOG_DEP+1:0] level,
    output logic               ram_wen,
    output logic [LOG_DEP-1:0] ram_waddr,
    output logic [LOG_DEP-1:0] ram_raddr,
    output logic [WIDTH-1:0]   ram_din,
    input  logic [WIDTH-1:0]   ram_dout
);

    logic [LOG_DEP-1:0] wptr;
    logic [LOG_DEP-1:0] rptr;
    logic [LOG_DEP:0]   ram_cnt;
    logic               rd_pend;
    logic [1:0]         occ;
    logic [WIDTH-1:0]   head_q;
    logic [WIDTH-1:0]   spare_q;
    logic [LOG_DEP+1:0] level_q;

    logic               push;
    logic               pop;
    logic               rd_issue;
    logic [2:0]         slots_used;
    logic [1:0]         occ_nxt;
    logic [WIDTH-1:0]   head_nxt;
    logic [WIDTH-1:0]   spare_nxt;
    logic [LOG_DEP:0]   ram_cnt_nxt;
    logic [LOG_DEP+1:0] level_nxt;

    // ram_cnt never exceeds DEPTH, so "ram_cnt < DEPTH" is just its MSB being clear.
    assign in_ready  = ~ram_cnt[LOG_DEP];
    assign out_valid = (occ != 2'd0);
    assign out_data  = head_q;
    assign level     = level_q;

    // Handshakes in a flush cycle are dropped; the whole state is cleared at the edge anyway.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Output-stage slots still claimed after this cycle's pop, counting the read already in flight.
    // Issuing only when fewer than 2 are claimed guarantees the returning word always has a slot.
    assign slots_used = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
    // ram_cnt is the pre-push count, so a word written this cycle is not readable until the next one.
    assign rd_issue   = (ram_cnt != '0) & (slots_used < 3'd2) & ~flush;

    assign ram_wen   = push;
    assign ram_waddr = wptr;
    assign ram_raddr = rptr;
    assign ram_din   = in_data;

    // Output stage: pop shifts spare into head, then returning RAM data fills the first free slot.
    always_comb begin
        occ_nxt   = occ;
        head_nxt  = head_q;
        spare_nxt = spare_q;
        if (pop) begin
            occ_nxt = occ - 2'd1;
            if (occ == 2'd2) begin
                head_nxt = spare_q;
            end
        end
        if (rd_pend) begin
            if (occ_nxt == 2'd0) begin
                head_nxt = ram_dout;
            end else begin
                spare_nxt = ram_dout;
            end
            occ_nxt = occ_nxt + 2'd1;
        end
    end

    always_comb begin
        ram_cnt_nxt = ram_cnt;
        case ({push, rd_issue})
            2'b10:   ram_cnt_nxt = ram_cnt + (LOG_DEP+1)'(1);
            2'b01:   ram_cnt_nxt = ram_cnt - (LOG_DEP+1)'(1);
            default: ram_cnt_nxt = ram_cnt;
        endcase
    end

    // Level is registered from the next-state terms so it tracks the flits held after this edge.
    assign level_nxt = {1'b0, ram_cnt_nxt}
                     + {{(LOG_DEP+1){1'b0}}, rd_issue}
                     + {{LOG_DEP{1'b0}}, occ_nxt};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            occ     <= 2'd0;
            head_q  <= '0;
            spare_q <= '0;
            level_q <= '0;
        end else if (flush) begin
            // Any read in flight is discarded by clearing rd_pend.
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            occ     <= 2'd0;
            head_q  <= '0;
            spare_q <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + LOG_DEP'(1);
            end
            if (rd_issue) begin
                rptr <= rptr + LOG_DEP'(1);
            end
            ram_cnt <= ram_cnt_nxt;
            rd_pend <= rd_issue;
            occ     <= occ_nxt;
            head_q  <= head_nxt;
            spare_q <= spare_nxt;
            level_q <= level_nxt;
        end
    end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Controller that turns the dual-port block-RAM buffer (1-cycle synchronous read, write-enable gated) into a first-word-fall-through FIFO with valid/ready on both sides.
- Sits between a router input link and the buffer RAM. It drives the RAM's write and read ports, consumes the RAM's registered read data, and presents the head flit to the downstream switch/arbiter stage.
- Total capacity is DEPTH RAM entries plus 2 output-stage registers.

Parameters:
- WIDTH, 36, flit width in bits; must match the RAM WIDTH.
- LOG_DEP, 6, log2 of RAM depth; DEPTH = 2**LOG_DEP.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all contents; priority over push/pop
- in_valid  input  1  upstream flit valid
- in_data  input  WIDTH  upstream flit
- in_ready  output  1  FIFO can accept a flit this cycle
- out_valid  output  1  head flit valid
- out_data  output  WIDTH  head flit
- out_ready  input  1  downstream consumes head this cycle
- level  output  LOG_DEP+2  total flits held: RAM + in-flight read + output stage
- ram_wen  output  1  RAM write enable; RAM enable is tied high at instantiation
- ram_waddr  output  LOG_DEP  RAM write address
- ram_raddr  output  LOG_DEP  RAM read address
- ram_din  output  WIDTH  RAM write data; equals in_data
- ram_dout  input  WIDTH  RAM registered read data, valid the cycle after ram_raddr is sampled

Behaviour:
- Reset (async, reset_n=0):
  - wptr, rptr, ram_cnt, rd_pend and the output-stage occupancy (0..2) all clear.
  - Outputs: in_ready=1, out_valid=0, out_data=0, level=0, ram_wen=0, ram_waddr=0, ram_raddr=0.
- Push:
  - push = in_valid & in_ready; in_ready = (ram_cnt < DEPTH).
  - ram_wen = push, combinational. ram_waddr = wptr. On push, wptr increments modulo DEPTH (natural wrap).
- Read issue:
  - rd_issue = (ram_cnt != 0) & (occ + rd_pend - pop < 2).
  - ram_raddr = rptr, combinational. On rd_issue, rptr increments modulo DEPTH; rd_pend is set next cycle, otherwise cleared.
- Read data: when rd_pend=1, ram_dout is written into the output stage (head slot if it is free after this cycle's pop, otherwise the spare slot). Capture never overflows.
- ram_cnt:
  - +1 on push, -1 on rd_issue, unchanged when both occur.
  - An entry becomes readable only in the cycle after its write, so a read never targets an address written in the same cycle. This makes read-during-write behaviour irrelevant.
- Output stage:
  - 2-entry register queue. out_valid = (occ != 0). out_data = head register.
  - pop = out_valid & out_ready. On pop, spare shifts to head.
- level = ram_cnt + rd_pend + occ, registered, updated every cycle.
- Latency:
  - Empty FIFO, push in cycle T: out_valid=1 in cycle T+3 (write T, read issue T+1, data T+2, head T+3).
  - Sustained throughput is 1 flit/cycle on both sides once primed.
- Full: ram_cnt=DEPTH forces in_ready=0. With the output stage also full, level = DEPTH+2. A push offered while full is ignored and does not corrupt state.
- Empty: out_valid=0, and out_data holds its last value (don't-care for checking).
- Simultaneous push and pop at any level: both take effect, and level is unchanged once the pipeline settles.
- Pointer wrap: pointers wrap DEPTH-1 -> 0 with no gap. Order is strictly preserved across the wrap.
- Flush:
  - At the next edge, everything returns to reset values; any in-flight RAM read is discarded (rd_pend cleared).
  - push and pop in the flush cycle are ignored.
- Reset asserted mid-operation: immediate return to reset values, and all stored flits are lost. The first push after release is written at address 0.

Test Plan:
- Single flit: after reset, push 0x0_0000_00A5 at cycle 10 -> out_valid rises at cycle 13 with out_data=0x0_0000_00A5; level goes 1 from cycle 11; pop at cycle 13 -> level=0 at cycle 14.
- Fill: push 66 flits (values 0..65) with out_ready=0 -> in_ready falls after 66 accepted, level=66; the 67th offered flit is ignored; then drain with out_ready=1 -> values 0..65 back to back, in order.
- Streaming wrap: in_valid and out_ready held at 1 for 200 cycles with an incrementing count -> output is an incrementing sequence with no gaps or duplicates, 1 flit/cycle after the first 3 cycles; ram_waddr wraps 63->0 at least 3 times.
- Random backpressure: random in_valid/out_ready at 50% for 5000 cycles -> scoreboard matches in order; level equals the model count every cycle; no push is accepted while in_ready=0.
- Flush with a read in flight: 5 flits stored, flush asserted the cycle after a rd_issue -> next cycle level=0, out_valid=0; a new push 0x123 appears at the output 3 cycles later from RAM address 0.
- Async reset mid-stream: assert reset_n=0 between clock edges during streaming -> outputs take reset values immediately, without waiting for an edge; after release, normal operation resumes from address 0.
